// File: rtl/unified_memory_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_memory_write_arbiter
//  Description : Owns the single aligned-only write port of the unified
//                memory. Arbitrates store requests from the core (req0) and
//                the program loader / debug port (req1) using valid/ready
//                handshakes. Aligned stores pass through as one beat;
//                misaligned half/word stores are split into sequential byte
//                beats. All memory-side outputs are registered.
//  Ports       :
//    clk                 - single clock, all state updates on posedge
//    reset               - synchronous, active-high reset
//    reqN_valid          - store request valid (N = 0 core, 1 loader/debug)
//    reqN_ready          - request accepted on this edge when valid & ready
//    reqN_addr [31:0]    - byte address
//    reqN_width[3:0]     - 1 = byte, 2 = half, 4 = word, others invalid
//    reqN_data [31:0]    - LSB-aligned store data
//    mem_write_en        - write strobe, memory commits on following edge
//    mem_write_width     - 1, 2 or 4
//    mem_addr_write      - write address, aligned to mem_write_width
//    mem_write_data      - LSB-aligned write data
//    busy                - an accepted request still has beats on the port
//    err_width           - one-cycle pulse: accepted request had bad width
//  Parameters  :
//    ROUND_ROBIN         - 1: alternate on contention, 0: req0 always wins
//  Revision    : 1.0 - initial release
// ============================================================================

module unified_memory_write_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [3:0]  req0_width,
    input  logic [31:0] req0_data,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [3:0]  req1_width,
    input  logic [31:0] req1_data,

    output logic        mem_write_en,
    output logic [3:0]  mem_write_width,
    output logic [31:0] mem_addr_write,
    output logic [31:0] mem_write_data,

    output logic        busy,
    output logic        err_width
);

    localparam logic [3:0] c_W_BYTE = 4'd1;
    localparam logic [3:0] c_W_HALF = 4'd2;
    localparam logic [3:0] c_W_WORD = 4'd4;

    // ST_IDLE : nothing on the port
    // ST_ISSUE: mem_* outputs hold a beat, r_beats_left counts this one and
    //           any still to follow
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t      r_state;
    logic [2:0]  r_beats_left;
    // Identity of the last granted requester: 1 = req1. Resetting it to 1
    // makes req0 win the first contended cycle.
    logic        r_last_grant;
    // Split-store context: address of the next byte beat and the bytes that
    // have not yet been issued (next one sits in bits [7:0]).
    logic [31:0] r_next_addr;
    logic [23:0] r_rem_data;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_slot_free;
    logic        w_accept;
    logic [31:0] w_sel_addr;
    logic [3:0]  w_sel_width;
    logic [31:0] w_sel_data;
    logic        w_width_ok;
    logic        w_aligned;

    // ------------------------------------------------------------------------
    // Arbitration. Grants depend only on valids and the pointer; the slot
    // check is applied afterwards so a grant never implies acceptance.
    // ------------------------------------------------------------------------
    generate
        if (ROUND_ROBIN != 0) begin : g_round_robin
            always_comb begin
                w_grant0 = 1'b0;
                w_grant1 = 1'b0;
                if (req0_valid && req1_valid) begin
                    w_grant0 = r_last_grant;
                    w_grant1 = ~r_last_grant;
                end else begin
                    w_grant0 = req0_valid;
                    w_grant1 = req1_valid;
                end
            end
        end else begin : g_fixed_priority
            always_comb begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid & ~req0_valid;
            end
        end
    endgenerate

    // A new request may be accepted when the port is empty or when the beat
    // currently presented is the last one of its request; the latter keeps
    // mem_write_en high with no bubble between requests.
    assign w_slot_free = (r_state == ST_IDLE) ||
                         ((r_state == ST_ISSUE) && (r_beats_left == 3'd1));

    assign req0_ready = w_slot_free & w_grant0;
    assign req1_ready = w_slot_free & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_sel_addr  = w_grant1 ? req1_addr  : req0_addr;
    assign w_sel_width = w_grant1 ? req1_width : req0_width;
    assign w_sel_data  = w_grant1 ? req1_data  : req0_data;

    assign w_width_ok = (w_sel_width == c_W_BYTE) ||
                        (w_sel_width == c_W_HALF) ||
                        (w_sel_width == c_W_WORD);

    assign w_aligned  = (w_sel_width == c_W_BYTE) ||
                        ((w_sel_width == c_W_HALF) && (w_sel_addr[0] == 1'b0)) ||
                        ((w_sel_width == c_W_WORD) && (w_sel_addr[1:0] == 2'b00));

    assign busy = (r_state == ST_ISSUE);

    // ------------------------------------------------------------------------
    // State machine and registered memory-side outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_beats_left    <= 3'd0;
            r_last_grant    <= 1'b1;
            r_next_addr     <= 32'd0;
            r_rem_data      <= 24'd0;
            mem_write_en    <= 1'b0;
            mem_write_width <= 4'd0;
            mem_addr_write  <= 32'd0;
            mem_write_data  <= 32'd0;
            err_width       <= 1'b0;
        end else begin
            err_width <= 1'b0;

            if (w_accept) begin
                r_last_grant <= w_grant1;

                if (!w_width_ok) begin
                    // Accepted but dropped. Any prior request has finished
                    // by now because acceptance needs a free slot.
                    err_width    <= 1'b1;
                    mem_write_en <= 1'b0;
                    r_state      <= ST_IDLE;
                    r_beats_left <= 3'd0;
                end else if (w_aligned) begin
                    mem_write_en    <= 1'b1;
                    mem_write_width <= w_sel_width;
                    mem_addr_write  <= w_sel_addr;
                    mem_write_data  <= w_sel_data;
                    r_state         <= ST_ISSUE;
                    r_beats_left    <= 3'd1;
                end else begin
                    // Misaligned half or word: first byte beat now, the
                    // remaining bytes at consecutive addresses (wrapping at
                    // 2^32) on following cycles.
                    mem_write_en    <= 1'b1;
                    mem_write_width <= c_W_BYTE;
                    mem_addr_write  <= w_sel_addr;
                    mem_write_data  <= {24'd0, w_sel_data[7:0]};
                    r_next_addr     <= w_sel_addr + 32'd1;
                    r_rem_data      <= w_sel_data[31:8];
                    r_state         <= ST_ISSUE;
                    r_beats_left    <= w_sel_width[2:0];
                end
            end else if ((r_state == ST_ISSUE) && (r_beats_left > 3'd1)) begin
                mem_write_en    <= 1'b1;
                mem_write_width <= c_W_BYTE;
                mem_addr_write  <= r_next_addr;
                mem_write_data  <= {24'd0, r_rem_data[7:0]};
                r_next_addr     <= r_next_addr + 32'd1;
                r_rem_data      <= {8'd0, r_rem_data[23:8]};
                r_beats_left    <= r_beats_left - 3'd1;
            end else begin
                // Last beat done (or nothing pending) and nothing new.
                mem_write_en <= 1'b0;
                r_state      <= ST_IDLE;
                r_beats_left <= 3'd0;
            end
        end
    end

endmodule

`default_nettype wire
